// File: rtl/control_sequencer_if.sv
// Strobe/handshake bundle between control_sequencer and the phase-1 CPU datapath.
interface control_sequencer_if #(
    parameter int unsigned REGS = 16
) ();

    // Sequencer inputs
    logic            run;
    logic [31:0]     ir;
    logic            mem_ready;
    logic            mdu_done;

    // Register file strobes (one-hot)
    logic [REGS-1:0] R_out;
    logic [REGS-1:0] R_in;

    // Datapath strobes
    logic            PCout;
    logic            IncPC;
    logic            MARin;
    logic            memRead;
    logic            MDRin;
    logic            MDRout;
    logic            IRin;
    logic            Yin;
    logic            Zin;
    logic            Zlowout;
    logic            Zhighout;
    logic            LOin;
    logic            HIin;
    logic [4:0]      alu_op;
    logic            mdu_start;

    // Status pulses
    logic            instr_done;
    logic            illegal;

    // Sequencer side
    modport master (
        input  run, ir, mem_ready, mdu_done,
        output R_out, R_in,
        output PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Zhighout, LOin, HIin,
        output alu_op, mdu_start, instr_done, illegal
    );

    // Datapath side
    modport slave (
        output run, ir, mem_ready, mdu_done,
        input  R_out, R_in,
        input  PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Zhighout, LOin, HIin,
        input  alu_op, mdu_start, instr_done, illegal
    );

endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit running fetch (T0-T2) and
// execute (T3-T6) for the phase-1 CPU datapath.
// Optional feature macro: MDU_STALL_EN -- when defined, T4 of MUL/DIV holds
// until mdu_done and issues a single mdu_start pulse on entry.
module control_sequencer #(
    parameter int unsigned REGS = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_t;

    state_t state;
    state_t state_next;
    state_t after_last;

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic             is_alu3;
    logic             is_muldiv;
    logic             decoded;

    // Local copies of the outputs, driven by the output decode
    logic [REGS-1:0]  r_out;
    logic [REGS-1:0]  r_in;
    logic             pc_out;
    logic             inc_pc;
    logic             mar_in;
    logic             mem_read;
    logic             mdr_in;
    logic             mdr_out;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             zlow_out;
    logic             zhigh_out;
    logic             lo_in;
    logic             hi_in;
    logic [OP_W-1:0]  alu_op;
    logic             mdu_start;
    logic             instr_done;
    logic             illegal;

    // Register index to one-hot strobe; indices beyond REGS drive nothing
    function automatic logic [REGS-1:0] onehot(input logic [REG_W-1:0] idx);
        return REGS'(1) << idx;
    endfunction

    // IR field extraction and opcode classification
    assign opcode    = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign is_alu3   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_OR);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign decoded   = is_alu3 || is_muldiv;

    // Final execute state chains straight into the next fetch while run is held
    assign after_last = bus.run ? T0 : IDLE;

    logic unused_ir_low;
    assign unused_ir_low = ^bus.ir[14:0];

`ifdef MDU_STALL_EN
    // Set while T4 of a MUL/DIV is waiting on the MDU, so mdu_start fires once
    logic mdu_wait;

    // Tracks whether the current T4 cycle is a repeat
    always_ff @(posedge clock) begin
        if (clear) begin
            mdu_wait <= 1'b0;
        end else begin
            mdu_wait <= (state == T4) && (state_next == T4);
        end
    end
`else
    logic unused_mdu_done;
    assign unused_mdu_done = bus.mdu_done;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = bus.run ? T0 : IDLE;
            T0:   state_next = T1;
            T1:   state_next = bus.mem_ready ? T2 : T1;
            T2:   state_next = decoded ? T3 : after_last;
            T3:   state_next = T4;
            T4: begin
`ifdef MDU_STALL_EN
                if (is_muldiv && !bus.mdu_done) begin
                    state_next = T4;
                end else begin
                    state_next = T5;
                end
`else
                state_next = T5;
`endif
            end
            T5:   state_next = is_muldiv ? T6 : after_last;
            T6:   state_next = after_last;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from registered state and IR
    always_comb begin
        r_out      = '0;
        r_in       = '0;
        pc_out     = 1'b0;
        inc_pc     = 1'b0;
        mar_in     = 1'b0;
        mem_read   = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        lo_in      = 1'b0;
        hi_in      = 1'b0;
        alu_op     = '0;
        mdu_start  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            IDLE: ;
            T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
            end
            T1: begin
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                illegal = !decoded;
            end
            T3: begin
                r_out = is_muldiv ? onehot(ra) : onehot(rb);
                y_in  = 1'b1;
            end
            T4: begin
                r_out  = is_muldiv ? onehot(rb) : onehot(rc);
                alu_op = opcode;
`ifdef MDU_STALL_EN
                if (is_muldiv) begin
                    z_in      = bus.mdu_done;
                    mdu_start = !mdu_wait;
                end else begin
                    z_in      = 1'b1;
                end
`else
                z_in   = 1'b1;
`endif
            end
            T5: begin
                zlow_out = 1'b1;
                if (is_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    r_in       = onehot(ra);
                    instr_done = 1'b1;
                end
            end
            T6: begin
                zhigh_out  = 1'b1;
                hi_in      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Drive the interface
    assign bus.R_out      = r_out;
    assign bus.R_in       = r_in;
    assign bus.PCout      = pc_out;
    assign bus.IncPC      = inc_pc;
    assign bus.MARin      = mar_in;
    assign bus.memRead    = mem_read;
    assign bus.MDRin      = mdr_in;
    assign bus.MDRout     = mdr_out;
    assign bus.IRin       = ir_in;
    assign bus.Yin        = y_in;
    assign bus.Zin        = z_in;
    assign bus.Zlowout    = zlow_out;
    assign bus.Zhighout   = zhigh_out;
    assign bus.LOin       = lo_in;
    assign bus.HIin       = hi_in;
    assign bus.alu_op     = alu_op;
    assign bus.mdu_start  = mdu_start;
    assign bus.instr_done = instr_done;
    assign bus.illegal    = illegal;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the phase-1 CPU datapath. It runs the instruction fetch and execute sequence T0–T6 and drives the strobes that the datapath's register, bus, memory and Z/HI/LO ports consume: R*out/R*in, MARin, MDRin/MDRout, memRead, PCout, IncPC, Yin, Zin, Zlowout/Zhighout, LOin/HIin and IRin. It sits beside the `CPU` datapath, takes the IR contents back as an input, and replaces hand-sequenced stimulus with a decided Moore FSM.

## Interface
Parameters:
- `REGS`, 16, number of general registers; sets the width of the one-hot register strobes.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `run`  in  1  permits a new fetch when the FSM is in IDLE.
- `ir`  in  32  IR register contents; valid from T3 onward.
- `mem_ready`  in  1  memory read data valid on `mDataIn`.
- `mdu_done`  in  1  multiplier/divider result ready (used only with `MDU_STALL_EN`).
- `R_out`  out  REGS  one-hot register-to-bus enables (bit n = Rnout).
- `R_in`  out  REGS  one-hot register load enables (bit n = Rnin).
- `PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin`  out  1 each  datapath strobes.
- `alu_op`  out  5  equal to `ir[31:27]` during T4, 0 otherwise.
- `mdu_start`  out  1  one-cycle start pulse to the MDU.
- `instr_done`  out  1  one-cycle pulse in the last execute state.
- `illegal`  out  1  one-cycle pulse on an undecoded opcode.

## Operation
- IR fields: opcode `[31:27]`, Ra `[26:23]`, Rb `[22:19]`, Rc `[18:15]`.
- Decoded opcodes:
  - 3-register ops: ADD 00011, SUB 00100, AND 00101, OR 00110.
  - MUL/DIV ops: MUL 01111, DIV 10000.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All outputs are a combinational decode of the registered state plus `ir`. Every strobe not listed for a state is 0.
- IDLE: all outputs 0. Goes to T0 if `run`=1, otherwise stays in IDLE.
- T0: PCout, MARin, IncPC.
- T1: memRead, MDRin. Stays in T1 while `mem_ready`=0; goes to T2 on the cycle `mem_ready`=1.
- T2: MDRout, IRin. Goes to T3 if the opcode decodes. Otherwise pulses `illegal`=1 for one cycle in T2 and returns to T0 (IDLE if `run`=0).
- 3-register ops:
  - T3: R_out[Rb], Yin.
  - T4: R_out[Rc], Zin.
  - T5: Zlowout, R_in[Ra], instr_done.
  - T5 returns to T0 (IDLE if `run`=0).
- MUL/DIV ops:
  - T3: R_out[Ra], Yin.
  - T4: R_out[Rb], Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, instr_done.
  - T6 returns to T0 (IDLE if `run`=0).
- One-hot rule: R_out and R_in each have at most one bit set. If Ra=Rb, that register simply drives in both T3 and T4.
- `clear` has priority in every state. The cycle after `clear` is sampled high, the FSM is in IDLE with all outputs 0, including mid-T1 stalls and mid-T4 stalls. Reset value of every output is 0.

## Timing
- Uncontended instruction latency, T0 to last state inclusive:
  - MUL/DIV: 7 cycles.
  - 3-register ops: 6 cycles.
- Each additional cycle of `mem_ready`=0 in T1 adds one cycle.
- `ir` is sampled combinationally from T3 on. The datapath loads IR at the end of T2.
- `run` is sampled only in IDLE and in the final execute state. Dropping `run` never aborts an instruction in progress.
- `instr_done` and `illegal` are never high in the same cycle.

## Configuration
- `MDU_STALL_EN` defined:
  - In T4 for MUL/DIV, `mdu_start`=1 only in the first T4 cycle.
  - R_out[Rb] is held for the whole of T4.
  - Zin=1 only in the cycle `mdu_done`=1; the FSM advances to T5 on that cycle.
  - 3-register ops are unaffected.
- `MDU_STALL_EN` not defined:
  - `mdu_start` is tied to 0 and `mdu_done` is ignored.
  - T4 is always one cycle with Zin=1.

## Test plan
- DIV R4,R5: `ir`=0x8228_0000, `run`=1, `mem_ready`=1 → required sequence:
  - T3: R_out=0x0010 with Yin.
  - T4: R_out=0x0020 with Zin and alu_op=5'b10000.
  - T5: Zlowout with LOin.
  - T6: Zhighout with HIin and instr_done.
  - Total 7 cycles, then back to T0.
- ADD R1,R2,R3: `ir`=0x1891_8000 → required sequence:
  - T3: R_out=0x0004 with Yin.
  - T4: R_out=0x0008 with Zin and alu_op=5'b00011.
  - T5: Zlowout with R_in=0x0002 and instr_done.
  - No HIin or LOin asserted at any point.
- Memory stall: `mem_ready` held 0 for 3 cycles → T1 lasts 4 cycles with memRead and MDRin held high; IRin is asserted exactly once.
- Illegal opcode: `ir`=0xF800_0000 → `illegal` pulses once in T2, no Yin is asserted, and the next state is T0.
- Reset mid-instruction: `clear`=1 during T4 of DIV → the next cycle is IDLE with all outputs 0; with `run`=1 a fresh T0 follows.
- With `MDU_STALL_EN`: `mdu_done` low for 5 T4 cycles → `mdu_start` pulses once, R_out=0x0020 is held for 6 cycles, and Zin is high only in the 6th cycle.
